// File: rtl/call_stack_pkg.sv
// Shared types for the return-address stack: PC width default and op decode.
// Latency: n/a (types and a pure decode function only).
// Backpressure: none; every stack op completes in one cycle.
package call_stack_pkg;

  localparam int PC_W = 12;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } op_e;

  // push&pop on an empty stack has no top to replace, so it degrades to a plain push.
  function automatic op_e decode_op(input logic push, input logic pop, input logic empty);
    op_e op;
    case ({push, pop})
      2'b10:   op = OP_PUSH;
      2'b01:   op = OP_POP;
      2'b11:   op = empty ? OP_PUSH : OP_REPLACE;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/call_stack_if.sv
// Bundle between the datapath/controller and the call stack.
// Latency: n/a (wires only); stack_out is combinational from the stack's top.
// Backpressure: none; full/empty are status only, misuse sets the sticky error flags.
// Signals: push/pop/stack_in (datapath -> stack); stack_out, count, empty, full,
//          overflow, underflow and, with CALL_STACK_HWM_EN defined, hwm (stack -> datapath).
interface call_stack_if
  import call_stack_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 8
);
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] stack_in;
  logic [WIDTH-1:0] stack_out;
  logic [PTR_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
`ifdef CALL_STACK_HWM_EN
  logic [PTR_W-1:0] hwm;

  modport master (output push, pop, stack_in,
                  input  stack_out, count, empty, full, overflow, underflow, hwm);
  modport slave  (input  push, pop, stack_in,
                  output stack_out, count, empty, full, overflow, underflow, hwm);
`else
  modport master (output push, pop, stack_in,
                  input  stack_out, count, empty, full, overflow, underflow);
  modport slave  (input  push, pop, stack_in,
                  output stack_out, count, empty, full, overflow, underflow);
`endif

endinterface

// File: rtl/call_stack_mem.sv
// DEPTH x WIDTH register array holding the return addresses.
// Latency: write lands at the posedge; read is combinational from i_raddr.
// Backpressure: none.
// Ports: i_clk, i_we/i_waddr/i_wdata (sync write), i_raddr/o_rdata (async read).
module call_stack_mem #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // Storage is deliberately never cleared; occupancy alone decides what is valid.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/call_stack.sv
// Return-address LIFO: CALL pushes pc+1, RET reads the top in the same cycle and pops at the edge.
// Latency: stack_out combinational; count/flags update at the posedge of the op.
// Backpressure: none; push-while-full and pop-while-empty are dropped and set sticky flags.
// Ports: clk, reset (sync, active-low), bus (call_stack_if.slave).
// Optional: CALL_STACK_HWM_EN adds bus.hwm, the peak occupancy since reset.
module call_stack
  import call_stack_pkg::*;
#(
  parameter int WIDTH = PC_W,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  call_stack_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int AW    = $clog2(DEPTH);

  logic [PTR_W-1:0] r_count;
  logic             r_overflow;
  logic             r_underflow;

  op_e              w_op;
  logic [PTR_W-1:0] w_count_nxt;
  logic             w_empty;
  logic             w_full;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [AW-1:0]    w_top_addr;
  logic [WIDTH-1:0] w_rdata;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == PTR_W'(DEPTH));
  assign w_top_addr = AW'(r_count - PTR_W'(1));
  assign w_op       = decode_op(bus.push, bus.pop, w_empty);

  always_comb begin
    w_count_nxt = r_count;
    w_we        = 1'b0;
    w_waddr     = w_top_addr;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we        = 1'b1;
          w_waddr     = AW'(r_count);
          w_count_nxt = r_count + PTR_W'(1);
        end
      end
      OP_POP: begin
        if (!w_empty) w_count_nxt = r_count - PTR_W'(1);
      end
      OP_REPLACE: w_we = 1'b1;
      default: ;
    endcase
  end

  // Reset wins over any op in the same cycle, including the array write.
  call_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we & reset),
    .i_waddr (w_waddr),
    .i_wdata (bus.stack_in),
    .i_raddr (w_top_addr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      // push&pop while full is a legal replace, so only a lone push overflows.
      if (bus.push && !bus.pop && w_full) r_overflow  <= 1'b1;
      if (bus.pop && w_empty)             r_underflow <= 1'b1;
    end
  end

`ifdef CALL_STACK_HWM_EN
  logic [PTR_W-1:0] r_hwm;

  // count never exceeds DEPTH, so tracking the max saturates naturally.
  always_ff @(posedge clk) begin
    if (!reset)                    r_hwm <= '0;
    else if (w_count_nxt > r_hwm)  r_hwm <= w_count_nxt;
  end

  assign bus.hwm = r_hwm;
`endif

  assign bus.stack_out = w_empty ? '0 : w_rdata;
  assign bus.count     = r_count;
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overflow  = r_overflow;
  assign bus.underflow = r_underflow;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack (WIDTH=12, DEPTH=8) with hand-computed expectations.
// Latency: inputs driven 1 time unit after a posedge, outputs checked 1 unit after the next.
// Backpressure: n/a.
module tb_call_stack;
  import call_stack_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  call_stack_if #(.WIDTH(12), .DEPTH(8)) bus ();

  call_stack #(.WIDTH(12), .DEPTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock with the given controls, then controls return to idle.
  task automatic cyc(input logic psh, input logic pp, input logic [11:0] din);
    bus.push     = psh;
    bus.pop      = pp;
    bus.stack_in = din;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 1'b0, 12'h000);
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b1;
    bus.push     = 1'b0;
    bus.pop      = 1'b0;
    bus.stack_in = '0;

    // 1: reset then idle
    do_reset();
    cyc(1'b0, 1'b0, 12'h000);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full), 32'd0);
    chk("rst_out",   32'(bus.stack_out), 32'h000);
    chk("rst_ovf",   32'(bus.overflow), 32'd0);
    chk("rst_udf",   32'(bus.underflow), 32'd0);
`ifdef CALL_STACK_HWM_EN
    chk("rst_hwm",   32'(bus.hwm), 32'd0);
`endif

    // 2: push three, pop three
    cyc(1'b1, 1'b0, 12'h101);
    cyc(1'b1, 1'b0, 12'h202);
    cyc(1'b1, 1'b0, 12'h303);
    chk("p3_count", 32'(bus.count), 32'd3);
    chk("p3_out",   32'(bus.stack_out), 32'h303);
    bus.pop = 1'b1;
    #1;
    chk("pop_same_cycle_out", 32'(bus.stack_out), 32'h303);
    cyc(1'b0, 1'b1, 12'h000);
    chk("pop1_out",   32'(bus.stack_out), 32'h202);
    chk("pop1_count", 32'(bus.count), 32'd2);
    cyc(1'b0, 1'b1, 12'h000);
    chk("pop2_out",   32'(bus.stack_out), 32'h101);
    cyc(1'b0, 1'b1, 12'h000);
    chk("pop3_empty", 32'(bus.empty), 32'd1);
    chk("pop3_out",   32'(bus.stack_out), 32'h000);
    chk("pop3_udf",   32'(bus.underflow), 32'd0);
`ifdef CALL_STACK_HWM_EN
    chk("pop3_hwm",   32'(bus.hwm), 32'd3);
`endif

    // 3: fill to DEPTH then one extra push
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1, 1'b0, 12'(16 + i));
      if (i == 7) begin
        chk("fill_full",    32'(bus.full), 32'd1);
        chk("fill_ovf_pre", 32'(bus.overflow), 32'd0);
      end
    end
    chk("ovf_flag",  32'(bus.overflow), 32'd1);
    chk("ovf_count", 32'(bus.count), 32'd8);
    chk("ovf_out",   32'(bus.stack_out), 32'h017);
    chk("ovf_full",  32'(bus.full), 32'd1);
    cyc(1'b1, 1'b1, 12'h3C3);
    chk("full_repl_count", 32'(bus.count), 32'd8);
    chk("full_repl_out",   32'(bus.stack_out), 32'h3C3);
    cyc(1'b0, 1'b1, 12'h000);
    chk("full_pop_out", 32'(bus.stack_out), 32'h016);
`ifdef CALL_STACK_HWM_EN
    chk("full_hwm", 32'(bus.hwm), 32'd8);
`endif

    // 4: underflow from empty, then push
    do_reset();
    chk("r2_ovf", 32'(bus.overflow), 32'd0);
    cyc(1'b0, 1'b1, 12'h000);
    chk("udf_flag",  32'(bus.underflow), 32'd1);
    chk("udf_count", 32'(bus.count), 32'd0);
    cyc(1'b1, 1'b0, 12'h0AA);
    chk("udf_push_count",  32'(bus.count), 32'd1);
    chk("udf_push_out",    32'(bus.stack_out), 32'h0AA);
    chk("udf_sticky",      32'(bus.underflow), 32'd1);

    // 5: replace top at count=2, then pop reveals untouched entry
    cyc(1'b1, 1'b0, 12'h050);
    chk("c2_out", 32'(bus.stack_out), 32'h050);
    cyc(1'b1, 1'b1, 12'h777);
    chk("repl_count", 32'(bus.count), 32'd2);
    chk("repl_out",   32'(bus.stack_out), 32'h777);
    cyc(1'b0, 1'b1, 12'h000);
    chk("repl_pop_out", 32'(bus.stack_out), 32'h0AA);
    cyc(1'b0, 1'b1, 12'h000);
    // push&pop on empty acts as push, still flags underflow
    do_reset();
    cyc(1'b1, 1'b1, 12'h123);
    chk("pp_empty_count", 32'(bus.count), 32'd1);
    chk("pp_empty_out",   32'(bus.stack_out), 32'h123);
    chk("pp_empty_udf",   32'(bus.underflow), 32'd1);

    // 6: reset with a concurrent push discards everything
    do_reset();
    cyc(1'b0, 1'b1, 12'h000);
    for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b0, 12'(i));
    chk("c5_count", 32'(bus.count), 32'd5);
    chk("c5_udf",   32'(bus.underflow), 32'd1);
`ifdef CALL_STACK_HWM_EN
    chk("c5_hwm",   32'(bus.hwm), 32'd5);
`endif
    reset = 1'b0;
    cyc(1'b1, 1'b0, 12'h666);
    reset = 1'b1;
    chk("rp_count", 32'(bus.count), 32'd0);
    chk("rp_empty", 32'(bus.empty), 32'd1);
    chk("rp_out",   32'(bus.stack_out), 32'h000);
    chk("rp_ovf",   32'(bus.overflow), 32'd0);
    chk("rp_udf",   32'(bus.underflow), 32'd0);
`ifdef CALL_STACK_HWM_EN
    chk("rp_hwm",   32'(bus.hwm), 32'd0);
`endif
    cyc(1'b1, 1'b0, 12'h0F0);
    chk("post_rst_count", 32'(bus.count), 32'd1);
    chk("post_rst_out",   32'(bus.stack_out), 32'h0F0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
